// File: rtl/pwm_multichannel.sv
// Purpose: CHANNELS PWM outputs sharing a prescaler and period counter, each with a duty register that is shadowed and applied at the period boundary.
// Latency: out and period_start are registered; enable changes reach out one clock later, and duty writes take effect from the next period.
// Backpressure: none; a duty write strobe is always taken in one clock, and a write to a channel index that does not exist is dropped.
module pwm_multichannel #(
  parameter int CHANNELS   = 16,
  parameter int RES        = 8,
  parameter int PRESCALE_W = 8,
  localparam int SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   en_out,
  input  logic [CHANNELS-1:0]   en_pwm,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  duty_wr,
  input  logic [SEL_W-1:0]      duty_sel,
  input  logic [RES-1:0]        duty_data,
  output logic [CHANNELS-1:0]   out,
  output logic                  period_start
);

  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic                  tick;
  logic [RES-1:0]        cnt_q, cnt_d;
  logic                  boundary;
  logic [CHANNELS-1:0]   wr_hit;
  logic [RES-1:0]        shadow_q [CHANNELS];
  logic [RES-1:0]        shadow_d [CHANNELS];
  logic [RES-1:0]        active_q [CHANNELS];
  logic [RES-1:0]        active_d [CHANNELS];
  logic [CHANNELS-1:0]   out_q, out_d;
  logic                  period_start_q, period_start_d;

  // Prescaler and period counter; '>=' makes a prescale drop below pre_cnt tick on the very next clock.
  always_comb begin
    tick           = (pre_cnt_q >= prescale);
    pre_cnt_d      = tick ? '0 : pre_cnt_q + 1'b1;
    cnt_d          = tick ? cnt_q + 1'b1 : cnt_q;
    boundary       = tick && (cnt_q == '1);
    period_start_d = boundary;
  end

  // Per-channel write decode; an index >= CHANNELS matches no channel, so the write is dropped.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = duty_wr && (duty_sel == SEL_W'(i));
    end
  end

  // Shadow update on write; active reloads at the boundary, taking a same-clock write directly.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
      if (wr_hit[i]) begin
        shadow_d[i] = duty_data;
      end
      if (boundary) begin
        active_d[i] = wr_hit[i] ? duty_data : shadow_q[i];
      end
    end
  end

  // Output function uses next-state cnt/active so out lines up with the cnt value it is registered alongside.
  always_comb begin
    out_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!en_out[i]) begin
        out_d[i] = 1'b0;
      end else if (!en_pwm[i]) begin
        out_d[i] = 1'b1;
      end else if (active_d[i] == '0) begin
        out_d[i] = 1'b0;
      end else if (active_d[i] == '1) begin
        out_d[i] = 1'b1;
      end else begin
        out_d[i] = (cnt_d < active_d[i]);
      end
    end
  end

  // Timebase and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q      <= '0;
      cnt_q          <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      cnt_q          <= cnt_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  // Duty registers; a reset discards any pending shadow value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule
